fc1_weight_buffer: RTL and testbench
====================================

# fc1_weight_buffer

Elastic weight buffer between the host write port (sel 3'b011 word stream) and the fcn fc1 engine. It decouples host bus timing from fc1 consumption. The host pushes 32-bit words, each packing NUM_PE signed int8 weights. The block holds them in a FIFO and presents one group at a time on a registered output. Each `fc1_next` from the control FSM retires the current group, and the block counts groups per inference.

## Interface
- NUM_PE, 4: weights per group; word width = 8*NUM_PE.
- DEPTH, 16: FIFO entries, excluding the output register; power of two.
- TOTAL_GROUPS, 330: groups per inference (IN1_N*OUT1_M/NUM_PE = 132*10/4).

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- clear  in  1  synchronous flush; empties storage and zeroes counters and flags.
- wr_valid  in  1  host word present.
- wr_data  in  8*NUM_PE  packed weights; byte p maps to group element p.
- wr_ready  out  1  word will be accepted this cycle.
- fc1_next  in  1  retire the current group.
- w_stream  out  NUM_PE x 8 signed  current group; registered.
- w_valid  out  1  w_stream holds an unconsumed group.
- level  out  $clog2(DEPTH+1)+1  words held, FIFO plus output register.
- group_cnt  out  $clog2(TOTAL_GROUPS)  groups retired this inference.
- last_group  out  1  w_valid high and group_cnt == TOTAL_GROUPS-1.
- done  out  1  one-cycle pulse when the last group retires.
- ovf  out  1  sticky: write attempted while not ready.
- unf  out  1  sticky: fc1_next while w_valid low.

## Operation
- Storage is a DEPTH-entry circular FIFO followed by one output register (OR).
- wr_ready = (fifo_count < DEPTH). It is combinational from state and does not depend on fc1_next.
- Accept = wr_valid & wr_ready.
- Pop = fc1_next & w_valid.
- Routing of an accepted word:
  - OR empty, or being popped, and FIFO empty: word goes straight into OR (bypass).
  - Otherwise: word goes into the FIFO tail.
- OR refill:
  - On pop with the FIFO non-empty, OR loads the FIFO head in the same edge.
  - On pop with the FIFO empty and no bypass write, w_valid falls.
- Unpacking: w_stream[p] = wr_data[8p+7:8p], taken as signed. No arithmetic is applied.
- Group counting:
  - Each pop increments group_cnt.
  - A pop at TOTAL_GROUPS-1 wraps group_cnt to 0 and pulses done.
- Rejected writes:
  - wr_valid & ~wr_ready sets ovf.
  - The word is dropped and contents are unchanged.
- Invalid retire: fc1_next & ~w_valid sets unf. State is otherwise unchanged.
- Precedence:
  - rst wins over everything.
  - clear wins over same-cycle writes and pops: both are ignored, and ovf/unf are not set that cycle.
- Pointers wrap modulo DEPTH. Full and empty are distinguished by fifo_count, not by pointer equality.

## Timing
- Reset or clear values:
  - w_valid=0, w_stream all 0, level=0, group_cnt=0.
  - done=0, ovf=0, unf=0, last_group=0, pointers=0.
  - wr_ready=1 in the first cycle after reset is released.
- Write-to-output latency:
  - A word accepted at edge t into an empty block gives w_valid=1 and valid w_stream from t+1.
  - Otherwise the word is visible one cycle after every earlier word has been popped.
- Pop-to-next latency: zero bubble. The next group is on w_stream in the cycle after the fc1_next edge whenever one is held.
- Simultaneous write and pop:
  - When full: wr_ready is 0, so the write is rejected even though a slot frees. level drops by 1.
  - When not full: level is unchanged.
- done asserts in the cycle after the retiring edge, for exactly one cycle.
- level = fifo_count + w_valid; its maximum is DEPTH+1.
- Reset mid-stream: all contents are lost and no done pulse is emitted.

## Structure
- Shared package npu_pkg holds:
  - NUM_PE, weight width 8, and the TOTAL_GROUPS derivation from IN1_N/OUT1_M.
  - The typedef for a signed int8 weight array [NUM_PE].
- One sub-module, sync_fifo (parameters WIDTH and DEPTH). It provides the count, push/pop and head output.
- The top holds the OR, the bypass mux, the counters and the sticky flags.

## Test plan
- Reset then single write 0x04FD0201:
  - Next cycle: w_valid=1, w_stream={1,2,-3,4}, level=1.
  - fc1_next gives w_valid=0, group_cnt=1.
- Fill test: write 17 words with no pops.
  - Expect level=17 and wr_ready=0.
  - An 18th write sets ovf and level stays 17.
  - Then 17 pops return the words in order with no bubbles.
- Stream of 330 groups with random backpressure:
  - done pulses exactly once, on the 330th pop.
  - group_cnt returns to 0; last_group is high only for group 329.
- fc1_next on an empty block: unf=1, group_cnt unchanged, w_valid stays 0.
- Simultaneous write and pop with level=1, FIFO empty:
  - The bypass loads the new word into OR and level stays 1.
  - Repeat at level=17: the write is rejected and level=16.
- clear asserted mid-stream with level=5 and a concurrent write: next cycle level=0, w_valid=0, ovf/unf=0, group_cnt=0.

Source files
------------

// File: rtl/npu_pkg.sv
// npu_pkg: shared NPU sizing and the fc1 weight group type.
package npu_pkg;
  localparam int NUM_PE = 4;
  localparam int W_BITS = 8;
  localparam int IN1_N = 132;
  localparam int OUT1_M = 10;
  localparam int TOTAL_GROUPS = IN1_N * OUT1_M / NUM_PE;
  typedef logic signed [W_BITS-1:0] weight_t;
  typedef weight_t [NUM_PE-1:0] w_group_t;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: circular FIFO with occupancy count and combinational head.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [CW-1:0]    count
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (clear) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= din;
  end
  assign dout  = mem_q[rd_ptr_q];
  assign count = count_q;
endmodule

// File: rtl/fc1_weight_buffer.sv
// fc1_weight_buffer: elastic FIFO + output register feeding fc1 weight groups,
// with per-inference group counting and sticky overflow/underflow flags.
module fc1_weight_buffer
  import npu_pkg::*;
#(
  parameter int NUM_PE = npu_pkg::NUM_PE,
  parameter int DEPTH = 16,
  parameter int TOTAL_GROUPS = npu_pkg::TOTAL_GROUPS,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int LW = CW + 1,
  localparam int GW = $clog2(TOTAL_GROUPS),
  localparam int WW = W_BITS * NUM_PE
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 wr_valid,
  input  logic [WW-1:0]        wr_data,
  output logic                 wr_ready,
  input  logic                 fc1_next,
  output weight_t [NUM_PE-1:0] w_stream,
  output logic                 w_valid,
  output logic [LW-1:0]        level,
  output logic [GW-1:0]        group_cnt,
  output logic                 last_group,
  output logic                 done,
  output logic                 ovf,
  output logic                 unf
);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [GW-1:0] LAST = GW'(TOTAL_GROUPS - 1);
  logic [CW-1:0] fifo_cnt;
  logic [WW-1:0] head, or_q, or_d;
  logic [GW-1:0] group_q, group_d;
  logic valid_q, valid_d, done_q, done_d, ovf_q, ovf_d, unf_q, unf_d;
  logic acc, pop, fifo_empty, bypass, fifo_push, fifo_pop;
  assign wr_ready = fifo_cnt < FULL;
  // A word skips the FIFO only when nothing older is queued ahead of it.
  always_comb begin
    acc        = wr_valid & wr_ready & ~clear;
    pop        = fc1_next & valid_q & ~clear;
    fifo_empty = fifo_cnt == '0;
    bypass     = acc & fifo_empty & (~valid_q | pop);
    fifo_push  = acc & ~bypass;
    fifo_pop   = pop & ~fifo_empty;
    or_d       = clear ? '0 : fifo_pop ? head : bypass ? wr_data : or_q;
    valid_d    = ~clear & (fifo_pop | bypass | (valid_q & ~pop));
    group_d    = clear ? '0 : ~pop ? group_q : (group_q == LAST) ? '0 : group_q + GW'(1);
    done_d     = pop & (group_q == LAST);
    ovf_d      = ~clear & (ovf_q | (wr_valid & ~wr_ready));
    unf_d      = ~clear & (unf_q | (fc1_next & ~valid_q));
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      or_q    <= '0;
      valid_q <= 1'b0;
      group_q <= '0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      or_q    <= or_d;
      valid_q <= valid_d;
      group_q <= group_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end
  sync_fifo #(.WIDTH(WW), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (wr_data),
    .dout  (head),
    .count (fifo_cnt)
  );
  assign w_stream   = or_q;
  assign w_valid    = valid_q;
  assign level      = LW'(fifo_cnt) + LW'(valid_q);
  assign group_cnt  = group_q;
  assign last_group = valid_q & (group_q == LAST);
  assign done       = done_q;
  assign ovf        = ovf_q;
  assign unf        = unf_q;
endmodule

// File: tb/tb_fc1_weight_buffer.sv
// tb_fc1_weight_buffer: directed + randomized checks against a queue model of all held words.
module tb_fc1_weight_buffer;
  import npu_pkg::*;
  localparam int DEPTH = 16;
  localparam int TG = npu_pkg::TOTAL_GROUPS;
  logic clk, rst, clear, wr_valid, wr_ready, fc1_next;
  logic [31:0] wr_data;
  weight_t [NUM_PE-1:0] w_stream;
  logic w_valid, last_group, done, ovf, unf;
  logic [5:0] level;
  logic [8:0] group_cnt;
  fc1_weight_buffer #(.NUM_PE(NUM_PE), .DEPTH(DEPTH), .TOTAL_GROUPS(TG)) dut (
    .clk(clk), .rst(rst), .clear(clear), .wr_valid(wr_valid), .wr_data(wr_data),
    .wr_ready(wr_ready), .fc1_next(fc1_next), .w_stream(w_stream), .w_valid(w_valid),
    .level(level), .group_cnt(group_cnt), .last_group(last_group), .done(done),
    .ovf(ovf), .unf(unf)
  );
  always #5 clk = ~clk;
  int checks = 0, passed = 0, failed = 0;
  logic [31:0] mq [$];
  int mg = 0, mpops = 0, dones = 0, pushed = 0;
  bit mdone = 0, movf = 0, munf = 0;
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask
  task automatic check_all();
    logic [31:0] ws;
    ws = w_stream;
    chk("w_valid", 32'(w_valid), 32'(mq.size() > 0));
    chk("level", 32'(level), 32'(mq.size()));
    chk("wr_ready", 32'(wr_ready), 32'(mq.size() <= DEPTH));
    chk("group_cnt", 32'(group_cnt), 32'(mg));
    chk("done", 32'(done), 32'(mdone));
    chk("ovf", 32'(ovf), 32'(movf));
    chk("unf", 32'(unf), 32'(munf));
    chk("last_group", 32'(last_group), 32'(mq.size() > 0 && mg == TG - 1));
    if (mq.size() > 0) chk("w_stream", ws, mq[0]);
  endtask
  task automatic model_flush();
    mq.delete();
    mg = 0;
    mdone = 0;
    movf = 0;
    munf = 0;
  endtask
  task automatic step(bit wv, logic [31:0] wd, bit nx, bit clr);
    bit ready, popping;
    wr_valid = wv;
    wr_data  = wd;
    fc1_next = nx;
    clear    = clr;
    ready    = mq.size() <= DEPTH;
    popping  = nx && mq.size() > 0;
    @(posedge clk);
    mdone = 0;
    if (clr) model_flush();
    else begin
      if (wv && !ready) movf = 1;
      if (nx && mq.size() == 0) munf = 1;
      if (popping) begin
        void'(mq.pop_front());
        mpops++;
        if (mg == TG - 1) begin
          mg = 0;
          mdone = 1;
        end else mg++;
      end
      if (wv && ready) mq.push_back(wd);
    end
    #1;
    wr_valid = 0;
    fc1_next = 0;
    clear    = 0;
    check_all();
  endtask
  initial begin
    bit wv, nx;
    logic [31:0] d;
    clk = 0; rst = 1; clear = 0; wr_valid = 0; wr_data = '0; fc1_next = 0;
    repeat (2) @(posedge clk);
    #1;
    check_all();
    chk("w_stream_reset", 32'(w_stream), 32'h0);
    rst = 0;
    #1;
    check_all();
    // single word, then retire it
    step(1, 32'h04FD0201, 0, 0);
    chk("w_stream2_signed", 32'($signed(w_stream[2])), 32'hFFFF_FFFD);
    chk("w_stream0", 32'($signed(w_stream[0])), 32'd1);
    step(0, '0, 1, 0);
    // fill to DEPTH+1, overflow, drain in order
    for (int i = 0; i < DEPTH + 1; i++) step(1, $urandom, 0, 0);
    step(1, $urandom, 0, 0);
    for (int i = 0; i < DEPTH + 1; i++) step(0, '0, 1, 0);
    step(0, '0, 0, 1);
    // retire on empty block
    step(0, '0, 1, 0);
    step(0, '0, 0, 1);
    // write+pop at level 1 and at full
    step(1, $urandom, 0, 0);
    step(1, $urandom, 1, 0);
    for (int i = 0; i < DEPTH; i++) step(1, $urandom, 0, 0);
    step(1, $urandom, 1, 0);
    step(0, '0, 0, 1);
    // clear with concurrent write at level 5
    for (int i = 0; i < 5; i++) step(1, $urandom, 0, 0);
    step(1, $urandom, 0, 1);
    // full inference stream with random backpressure
    mpops = 0;
    for (int c = 0; c < 6000 && mpops < TG; c++) begin
      wv = pushed < TG && $urandom_range(0, 3) != 0;
      nx = $urandom_range(0, 1) == 1;
      d  = $urandom;
      if (wv && mq.size() <= DEPTH) pushed++;
      step(wv, d, nx, 0);
      if (done) dones++;
    end
    chk("stream_pops", 32'(mpops), 32'(TG));
    chk("done_count", 32'(dones), 32'd1);
    // asynchronous reset mid-stream drops everything without a done pulse
    for (int i = 0; i < 3; i++) step(1, $urandom, 0, 0);
    step(0, '0, 1, 0);
    #2;
    rst = 1;
    model_flush();
    #1;
    check_all();
    @(posedge clk);
    #1;
    rst = 0;
    check_all();
    step(1, $urandom, 0, 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
